uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (8-bit byte plus 1-cycle valid pulse) and decodes register-access frames.
- Issues single-word read/write transactions on the internal register bus.
- Returns a response byte stream to the UART transmitter through a start/busy handshake.
- Aborts partial frames on an inter-byte timeout.

Parameters:
- ADDR_W, 8, register address width (the address frame byte is zero-extended or truncated to ADDR_W).
- DATA_W, 32, register data width; must be a multiple of 8. NB = DATA_W/8 bytes per data word.
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed between frame bytes, and for reg_ack, before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_byte  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  1-cycle pulse, new byte on rx_byte
- reg_addr  out  ADDR_W  register bus address
- reg_wdata  out  DATA_W  register bus write data
- reg_wr  out  1  1-cycle write strobe
- reg_rd  out  1  1-cycle read strobe
- reg_rdata  in  DATA_W  read data, sampled when reg_ack=1
- reg_ack  in  1  transaction complete, any cycle after the strobe
- tx_data  out  8  byte to transmit
- tx_start  out  1  1-cycle transmit request
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start, falls when done
- busy  out  1  high whenever state != IDLE
- rx_drop  out  1  1-cycle pulse, byte arrived while not accepting
- frame_err  out  1  1-cycle pulse on timeout or bad command

Behaviour:
- Reset values: all outputs 0. State=IDLE. Byte counter and timeout counter cleared. Reset mid-frame or mid-transaction abandons it silently, with no response sent.
- Frame formats:
  - Write: 0x57 'W', ADDR, then NB data bytes MSB first.
  - Read: 0x52 'R', ADDR.
- Responses:
  - Write success: 0x4B 'K'.
  - Read success: NB bytes of reg_rdata, MSB first.
  - Any error: 0x45 'E'.
- States: IDLE, GET_ADDR, GET_DATA, BUS_REQ, BUS_WAIT, TX_SEND, TX_HOLD, TX_WAIT.
- IDLE:
  - rx_valid with 0x57 or 0x52 latches the op and goes to GET_ADDR.
  - Any other byte: frame_err pulse, response 'E', goes to TX_SEND.
- GET_ADDR: on rx_valid, latch reg_addr. Write goes to GET_DATA (byte count=0); read goes to BUS_REQ.
- GET_DATA: each rx_valid shifts the byte into reg_wdata LSB end (previous contents move up 8). After the NB-th byte, go to BUS_REQ.
- BUS_REQ: reg_wr or reg_rd=1 for exactly this one cycle, then go to BUS_WAIT. The strobe asserts the cycle after the last frame byte's rx_valid.
- BUS_WAIT:
  - reg_ack=1: for a read, capture reg_rdata into the shift register; response = 'K' (write) or NB data bytes (read); go to TX_SEND.
  - reg_ack in the same cycle as the strobe is ignored; ack counts only in BUS_WAIT.
- TX_SEND: when tx_busy=0, drive tx_data and pulse tx_start for 1 cycle, then go to TX_HOLD. If tx_busy=1, wait.
- TX_HOLD: one cycle, lets tx_busy rise; go to TX_WAIT.
- TX_WAIT: when tx_busy=0, if bytes remain go to TX_SEND with the next byte (MSB first); else go to IDLE.
- Timeout counter:
  - Cleared on every accepted byte, on entry to GET_ADDR/GET_DATA/BUS_WAIT, and in all other states.
  - Increments each cycle in GET_ADDR, GET_DATA, BUS_WAIT.
  - Reaching TIMEOUT_CYCLES in GET_ADDR/GET_DATA: frame_err pulse, go to IDLE, no response.
  - Reaching TIMEOUT_CYCLES in BUS_WAIT: frame_err pulse, response 'E'.
- rx_valid in BUS_REQ, BUS_WAIT or any TX state: byte discarded, rx_drop pulse, state unaffected.
- rx_valid in the same cycle as a timeout: the timeout wins and the byte is discarded; this is the abort cycle, not an accept.
- reg_addr/reg_wdata hold their last values outside strobes.

Test Plan:
- Write 0x57,0x10,0xDE,0xAD,0xBE,0xEF, then ack 3 cycles after strobe → reg_wr one cycle after last byte, reg_addr=0x10, reg_wdata=0xDEADBEEF; single tx byte 0x4B.
- Read 0x52,0x04 with reg_rdata=0x12345678, ack 1 cycle after reg_rd → tx bytes 0x12,0x34,0x56,0x78 in order, each tx_start only after tx_busy falls.
- Bad command 0x41 → frame_err pulse, tx byte 0x45, no reg_wr/reg_rd; next 0x52,0x00 frame decodes normally.
- 0x57,0x20,0xAA then silence with TIMEOUT_CYCLES=50 → frame_err on cycle 50 after 0xAA, no response, busy=0; a fresh write then completes correctly.
- Read with reg_ack never asserted → frame_err after TIMEOUT_CYCLES, tx byte 0x45. Bytes sent during BUS_WAIT each pulse rx_drop.
- Assert rst during GET_DATA and during TX_WAIT → all outputs 0 immediately, state IDLE, no further tx_start.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
// Bundles every non-clock/reset signal of uart_cmd_parser: the UART receive
// byte stream, the internal register bus and the UART transmit handshake,
// plus the parser status pulses.
//
// Modports
//   slave  : the parser's view (receives bytes, drives the register bus and
//            the transmitter request, reports status)
//   master : the surrounding system's view (UART rx/tx, register file)
//
// Signals
//   rx_byte/rx_valid      : received byte + 1-cycle valid pulse
//   reg_addr/reg_wdata    : register bus address / write data
//   reg_wr/reg_rd         : 1-cycle write / read strobes
//   reg_rdata/reg_ack     : read data / transaction complete
//   tx_data/tx_start      : byte to transmit + 1-cycle request
//   tx_busy               : transmitter busy
//   busy/rx_drop/frame_err: parser status
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_wr;
   logic              reg_rd;
   logic [DATA_W-1:0] reg_rdata;
   logic              reg_ack;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              busy;
   logic              rx_drop;
   logic              frame_err;

   modport slave (
      input  rx_byte, rx_valid, reg_rdata, reg_ack, tx_busy,
      output reg_addr, reg_wdata, reg_wr, reg_rd, tx_data, tx_start,
             busy, rx_drop, frame_err
   );

   modport master (
      output rx_byte, rx_valid, reg_rdata, reg_ack, tx_busy,
      input  reg_addr, reg_wdata, reg_wr, reg_rd, tx_data, tx_start,
             busy, rx_drop, frame_err
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Decodes register-access frames arriving from a UART receiver, issues one
// read or write on the register bus per frame, and streams a response back
// to the UART transmitter.
//
//   Write frame : 'W'(0x57), ADDR, NB data bytes MSB first -> response 'K'
//   Read frame  : 'R'(0x52), ADDR                          -> NB bytes, MSB first
//   Any error   : response 'E'(0x45) (bad command, bus ack timeout)
//   Inter-byte timeout inside a frame aborts it with no response.
//
// Ports
//   clk  : system clock
//   rst  : asynchronous active-high reset; abandons any frame silently
//   bus  : uart_cmd_parser_if.slave (rx stream, register bus, tx handshake,
//          status). All outputs are registered.
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   uart_cmd_parser_if.slave    bus
);

   localparam int NB        = DATA_W / 8;
   localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BC_W      = $clog2(NB + 1);
   localparam int RSP_SHIFT = DATA_W - 8;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_GET_ADDR = 3'd1;
   localparam logic [2:0] ST_GET_DATA = 3'd2;
   localparam logic [2:0] ST_BUS_REQ  = 3'd3;
   localparam logic [2:0] ST_BUS_WAIT = 3'd4;
   localparam logic [2:0] ST_TX_SEND  = 3'd5;
   localparam logic [2:0] ST_TX_HOLD  = 3'd6;
   localparam logic [2:0] ST_TX_WAIT  = 3'd7;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BC_W-1:0]  BC_ZERO  = {BC_W{1'b0}};
   localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
   localparam logic [BC_W-1:0]  BC_NB    = BC_W'(NB);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NB - 1);

   // Places a single response byte at the MSB end of the tx shift register,
   // where the transmit path always takes its next byte from.
   function automatic logic [DATA_W-1:0] rsp_word(input logic [7:0] b);
      return DATA_W'(b) << RSP_SHIFT;
   endfunction

   logic [2:0]        r_state,     w_state_nxt;
   logic              r_op_wr,     w_op_wr_nxt;
   logic [BC_W-1:0]   r_bcnt,      w_bcnt_nxt;
   logic [CNT_W-1:0]  r_to_cnt,    w_to_cnt_nxt;
   logic [DATA_W-1:0] r_shift,     w_shift_nxt;
   logic [BC_W-1:0]   r_left,      w_left_nxt;
   logic [ADDR_W-1:0] r_reg_addr,  w_reg_addr_nxt;
   logic [DATA_W-1:0] r_reg_wdata, w_reg_wdata_nxt;
   logic              r_reg_wr,    w_reg_wr_nxt;
   logic              r_reg_rd,    w_reg_rd_nxt;
   logic [7:0]        r_tx_data,   w_tx_data_nxt;
   logic              r_tx_start,  w_tx_start_nxt;
   logic              r_busy;
   logic              r_rx_drop,   w_rx_drop_nxt;
   logic              r_frame_err, w_frame_err_nxt;
   logic              w_timeout;

   // Counter sits at TIMEOUT_CYCLES-1 after that many idle cycles; the next
   // cycle in a waiting state is the abort cycle.
   assign w_timeout = (r_to_cnt == CNT_LAST);

   // Next-state and next-output decode for the frame FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_op_wr_nxt     = r_op_wr;
      w_bcnt_nxt      = r_bcnt;
      w_to_cnt_nxt    = CNT_ZERO;
      w_shift_nxt     = r_shift;
      w_left_nxt      = r_left;
      w_reg_addr_nxt  = r_reg_addr;
      w_reg_wdata_nxt = r_reg_wdata;
      w_reg_wr_nxt    = 1'b0;
      w_reg_rd_nxt    = 1'b0;
      w_tx_data_nxt   = r_tx_data;
      w_tx_start_nxt  = 1'b0;
      w_rx_drop_nxt   = 1'b0;
      w_frame_err_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.rx_valid) begin
               if ((bus.rx_byte == CMD_WR) || (bus.rx_byte == CMD_RD)) begin
                  w_op_wr_nxt = (bus.rx_byte == CMD_WR);
                  w_state_nxt = ST_GET_ADDR;
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_shift_nxt     = rsp_word(RSP_ERR);
                  w_left_nxt      = BC_ONE;
                  w_state_nxt     = ST_TX_SEND;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_GET_ADDR: begin
            // Timeout beats a byte arriving in the same cycle.
            if (w_timeout) begin
               w_frame_err_nxt = 1'b1;
               w_rx_drop_nxt   = bus.rx_valid;
               w_state_nxt     = ST_IDLE;
            end else if (bus.rx_valid) begin
               w_reg_addr_nxt = ADDR_W'(bus.rx_byte);
               if (r_op_wr) begin
                  w_bcnt_nxt  = BC_ZERO;
                  w_state_nxt = ST_GET_DATA;
               end else begin
                  w_reg_rd_nxt = 1'b1;
                  w_state_nxt  = ST_BUS_REQ;
               end
            end else begin
               w_to_cnt_nxt = r_to_cnt + CNT_ONE;
            end
         end

         ST_GET_DATA: begin
            if (w_timeout) begin
               w_frame_err_nxt = 1'b1;
               w_rx_drop_nxt   = bus.rx_valid;
               w_state_nxt     = ST_IDLE;
            end else if (bus.rx_valid) begin
               w_reg_wdata_nxt = (r_reg_wdata << 4'd8) | DATA_W'(bus.rx_byte);
               if (r_bcnt == BC_LAST) begin
                  w_reg_wr_nxt = 1'b1;
                  w_state_nxt  = ST_BUS_REQ;
               end else begin
                  w_bcnt_nxt = r_bcnt + BC_ONE;
               end
            end else begin
               w_to_cnt_nxt = r_to_cnt + CNT_ONE;
            end
         end

         ST_BUS_REQ: begin
            // Strobe is high during this state; any ack seen now is ignored.
            w_rx_drop_nxt = bus.rx_valid;
            w_state_nxt   = ST_BUS_WAIT;
         end

         ST_BUS_WAIT: begin
            w_rx_drop_nxt = bus.rx_valid;
            if (w_timeout) begin
               w_frame_err_nxt = 1'b1;
               w_shift_nxt     = rsp_word(RSP_ERR);
               w_left_nxt      = BC_ONE;
               w_state_nxt     = ST_TX_SEND;
            end else if (bus.reg_ack) begin
               if (r_op_wr) begin
                  w_shift_nxt = rsp_word(RSP_OK);
                  w_left_nxt  = BC_ONE;
               end else begin
                  w_shift_nxt = bus.reg_rdata;
                  w_left_nxt  = BC_NB;
               end
               w_state_nxt = ST_TX_SEND;
            end else begin
               w_to_cnt_nxt = r_to_cnt + CNT_ONE;
            end
         end

         ST_TX_SEND: begin
            w_rx_drop_nxt = bus.rx_valid;
            if (!bus.tx_busy) begin
               w_tx_data_nxt  = r_shift[DATA_W-1 -: 8];
               w_shift_nxt    = r_shift << 4'd8;
               w_left_nxt     = r_left - BC_ONE;
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = ST_TX_HOLD;
            end else begin
               w_state_nxt = ST_TX_SEND;
            end
         end

         ST_TX_HOLD: begin
            // Gives the transmitter one cycle to raise tx_busy.
            w_rx_drop_nxt = bus.rx_valid;
            w_state_nxt   = ST_TX_WAIT;
         end

         ST_TX_WAIT: begin
            w_rx_drop_nxt = bus.rx_valid;
            if (!bus.tx_busy) begin
               if (r_left != BC_ZERO) begin
                  w_state_nxt = ST_TX_SEND;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_state_nxt = ST_TX_WAIT;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op_wr     <= 1'b0;
         r_bcnt      <= BC_ZERO;
         r_to_cnt    <= CNT_ZERO;
         r_shift     <= {DATA_W{1'b0}};
         r_left      <= BC_ZERO;
         r_reg_addr  <= {ADDR_W{1'b0}};
         r_reg_wdata <= {DATA_W{1'b0}};
         r_reg_wr    <= 1'b0;
         r_reg_rd    <= 1'b0;
         r_tx_data   <= 8'h00;
         r_tx_start  <= 1'b0;
         r_busy      <= 1'b0;
         r_rx_drop   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_op_wr     <= w_op_wr_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_to_cnt    <= w_to_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_left      <= w_left_nxt;
         r_reg_addr  <= w_reg_addr_nxt;
         r_reg_wdata <= w_reg_wdata_nxt;
         r_reg_wr    <= w_reg_wr_nxt;
         r_reg_rd    <= w_reg_rd_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_tx_start  <= w_tx_start_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_rx_drop   <= w_rx_drop_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   assign bus.reg_addr  = r_reg_addr;
   assign bus.reg_wdata = r_reg_wdata;
   assign bus.reg_wr    = r_reg_wr;
   assign bus.reg_rd    = r_reg_rd;
   assign bus.tx_data   = r_tx_data;
   assign bus.tx_start  = r_tx_start;
   assign bus.busy      = r_busy;
   assign bus.rx_drop   = r_rx_drop;
   assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed and randomized frames against uart_cmd_parser with a small
// transmitter model. Expected bus transactions and response bytes are
// derived from the frame contents (write -> 'K', read -> data bytes MSB
// first, error -> 'E').
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int NB     = DATA_W / 8;
   localparam int TO     = 50;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_cmd_parser_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   uart_cmd_parser #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass   = 0;
   int n_checks = 0;
   int n_fail   = 0;

   // Transmitter model: busy rises the cycle after tx_start, stays tx_len cycles.
   int   tx_len = 2;
   int   tx_cnt;
   logic tx_busy_m;
   assign bus.tx_busy = tx_busy_m;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_busy_m <= 1'b0;
         tx_cnt    <= 0;
      end else if (bus.tx_start) begin
         tx_busy_m <= 1'b1;
         tx_cnt    <= tx_len;
      end else if (tx_cnt > 1) begin
         tx_cnt <= tx_cnt - 1;
      end else begin
         tx_cnt    <= 0;
         tx_busy_m <= 1'b0;
      end
   end

   // Monitor: collects transmitted bytes and counts status pulses.
   logic [7:0] q_tx[$];
   int n_wr = 0, n_rd = 0, n_ferr = 0, n_drop = 0, n_bad_start = 0;
   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         q_tx.push_back(bus.tx_data);
         if (bus.tx_busy) n_bad_start++;
      end
      if (bus.reg_wr === 1'b1)    n_wr++;
      if (bus.reg_rd === 1'b1)    n_rd++;
      if (bus.frame_err === 1'b1) n_ferr++;
      if (bus.rx_drop === 1'b1)   n_drop++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.reg_ack = 1'b1;
      tick();
      bus.reg_ack = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((bus.busy || bus.tx_busy) && k < budget) begin
         tick();
         k++;
      end
      check("idle_within_budget", k < budget, 1'b1);
      idle(2);
   endtask

   task automatic compare_tx(input string tag, input logic [7:0] exp_q[$]);
      check({tag, "_tx_count"}, q_tx.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < q_tx.size(); i++)
         check({tag, "_tx_byte"}, q_tx[i], exp_q[i]);
      q_tx.delete();
   endtask

   // One complete frame checked against the reference rules.
   task automatic do_frame(input bit is_wr, input logic [7:0] addr, input logic [31:0] data,
                           input int ack_dly, input int gap);
      logic [7:0] exp_q[$];
      int wr0, rd0;
      wr0 = n_wr;
      rd0 = n_rd;
      if (is_wr) exp_q.push_back(8'h4B);
      else for (int i = 0; i < NB; i++) exp_q.push_back(8'((data >> (8 * (NB - 1 - i))) & 32'hFF));
      bus.reg_rdata = is_wr ? $urandom : data;
      send_byte(is_wr ? 8'h57 : 8'h52);
      idle(gap);
      send_byte(addr);
      if (is_wr) begin
         for (int i = 0; i < NB; i++) begin
            idle(gap);
            send_byte(data[31 - 8 * i -: 8]);
         end
      end
      check(is_wr ? "wr_strobe_next_cycle" : "rd_strobe_next_cycle",
            is_wr ? bus.reg_wr : bus.reg_rd, 1'b1);
      check("strobe_other_low", is_wr ? bus.reg_rd : bus.reg_wr, 1'b0);
      check("reg_addr", bus.reg_addr, addr);
      if (is_wr) check("reg_wdata", bus.reg_wdata, data);
      tick();
      check("strobe_one_cycle", {bus.reg_wr, bus.reg_rd}, 2'b00);
      idle(ack_dly - 1);
      pulse_ack();
      wait_idle(500);
      compare_tx(is_wr ? "write" : "read", exp_q);
      check("wr_count", n_wr - wr0, is_wr ? 1 : 0);
      check("rd_count", n_rd - rd0, is_wr ? 0 : 1);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.reg_addr, bus.reg_wdata, bus.reg_wr, bus.reg_rd, bus.tx_data,
                  bus.tx_start, bus.busy, bus.rx_drop, bus.frame_err});
   endfunction

   initial begin
      logic [7:0] exp_q[$];
      int k, f0, d0, s0;

      rst           = 1'b1;
      bus.rx_byte   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus.reg_ack   = 1'b0;
      bus.reg_rdata = '0;
      idle(3);
      check("reset_outputs", all_outs(), 64'd0);
      rst = 1'b0;
      idle(2);

      // Write with ack 3 cycles after the strobe.
      tx_len = 3;
      do_frame(1'b1, 8'h10, 32'hDEADBEEF, 3, 0);

      // Read with ack 1 cycle after the strobe.
      do_frame(1'b0, 8'h04, 32'h12345678, 1, 0);

      // Bad command, then a normal read.
      s0 = n_wr + n_rd;
      send_byte(8'h41);
      check("bad_cmd_frame_err", bus.frame_err, 1'b1);
      tick();
      check("frame_err_one_cycle", bus.frame_err, 1'b0);
      wait_idle(200);
      exp_q = '{8'h45};
      compare_tx("bad_cmd", exp_q);
      check("bad_cmd_no_strobe", n_wr + n_rd, s0);
      do_frame(1'b0, 8'h00, 32'h0BADF00D, 2, 1);

      // Inter-byte timeout mid-write, then a fresh write.
      send_byte(8'h57);
      send_byte(8'h20);
      send_byte(8'hAA);
      k = 0;
      while (!bus.frame_err && k < 200) begin
         tick();
         k++;
      end
      check("timeout_latency", k, TO);
      tick();
      check("timeout_busy_low", bus.busy, 1'b0);
      idle(10);
      check("timeout_no_response", q_tx.size(), 0);
      do_frame(1'b1, 8'h21, 32'h01020304, 2, 2);

      // Read never acked; bytes during BUS_WAIT are dropped.
      d0 = n_drop;
      f0 = n_ferr;
      send_byte(8'h52);
      send_byte(8'h07);
      tick();
      send_byte(8'h57);
      check("drop_pulse_1", bus.rx_drop, 1'b1);
      tick();
      send_byte(8'h11);
      check("drop_pulse_2", bus.rx_drop, 1'b1);
      k = 0;
      while (!bus.frame_err && k < 200) begin
         tick();
         k++;
      end
      check("ack_timeout_seen", bus.frame_err, 1'b1);
      wait_idle(200);
      check("drop_count", n_drop - d0, 2);
      check("ack_timeout_ferr_count", n_ferr - f0, 1);
      exp_q = '{8'h45};
      compare_tx("ack_timeout", exp_q);

      // Ack during the strobe cycle is ignored.
      bus.reg_rdata = 32'hCAFEF00D;
      send_byte(8'h52);
      send_byte(8'h09);
      check("rd_strobe_for_early_ack", bus.reg_rd, 1'b1);
      pulse_ack();
      idle(8);
      check("early_ack_still_busy", bus.busy, 1'b1);
      check("early_ack_no_tx", q_tx.size(), 0);
      pulse_ack();
      wait_idle(500);
      exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      compare_tx("late_ack", exp_q);

      // Reset during GET_DATA.
      s0 = n_wr;
      send_byte(8'h57);
      send_byte(8'h30);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      #1;
      check("rst_get_data_outputs", all_outs(), 64'd0);
      tick();
      rst = 1'b0;
      idle(20);
      check("rst_get_data_no_tx", q_tx.size(), 0);
      check("rst_get_data_no_wr", n_wr, s0);

      // Reset during TX_WAIT.
      tx_len = 30;
      bus.reg_rdata = 32'hA5C3E1F0;
      send_byte(8'h52);
      send_byte(8'h40);
      pulse_ack();
      k = 0;
      while (q_tx.size() < 1 && k < 100) begin
         tick();
         k++;
      end
      idle(3);
      rst = 1'b1;
      #1;
      check("rst_tx_wait_outputs", all_outs(), 64'd0);
      tick();
      rst = 1'b0;
      idle(40);
      check("rst_tx_wait_one_byte", q_tx.size(), 1);
      q_tx.delete();

      // Randomized frames.
      for (int i = 0; i < 10; i++) begin
         tx_len = $urandom_range(1, 5);
         do_frame(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                  $urandom_range(1, 6), $urandom_range(0, 3));
      end

      check("tx_start_never_while_busy", n_bad_start, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
